// File: rtl/prog_loader.sv
// prog_loader: streams machine code into instruction memory from address 0, then releases, starts and times the core.
module prog_loader #(
  parameter int D       = 12,
  parameter int W       = 9,
  parameter int CW      = 16,
  parameter int MAX_CYC = 4000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         im_wr_en,
  output logic [D-1:0] im_wr_addr,
  output logic [W-1:0] im_wr_data,
  output logic         core_reset,
  output logic         core_req,
  input  logic         core_done,
  input  logic         rearm,
  output logic         busy,
  output logic         ok,
  output logic         timed_out,
  output logic         overflow,
  output logic [D:0]   word_count,
  output logic [CW-1:0] cycle_count
);
  typedef enum logic [2:0] {LOAD, RELEASE, REQ, RUN, DONE, TMO, OVF} state_t;
  state_t state, nxt;
  logic accept, clear;
  logic [D:0] next_addr;
  assign in_ready   = state == LOAD;
  assign busy       = state inside {RELEASE, REQ, RUN};
  // core leaves reset one cycle after the final write lands, and stays out until a terminal state
  assign core_reset = !(state inside {REQ, RUN});
  assign im_wr_addr = word_count[D-1:0];
  assign accept     = in_valid & in_ready;
  // address of the word being accepted, accounting for a write still in flight
  assign next_addr  = word_count + {{D{1'b0}}, im_wr_en};
  assign clear      = (state inside {DONE, TMO, OVF}) & rearm;
  always_comb begin
    nxt = state;
    case (state)
      LOAD:    nxt = !accept ? LOAD : in_last ? RELEASE : (&next_addr[D-1:0]) ? OVF : LOAD;
      RELEASE: nxt = REQ;
      REQ:     nxt = RUN;
      RUN:     nxt = core_done ? DONE : (cycle_count == CW'(MAX_CYC - 1)) ? TMO : RUN;
      DONE, TMO, OVF: nxt = rearm ? LOAD : state;
      default: nxt = LOAD;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LOAD;
      im_wr_en    <= 1'b0;
      im_wr_data  <= '0;
      word_count  <= '0;
      cycle_count <= '0;
      core_req    <= 1'b0;
      ok          <= 1'b0;
      timed_out   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= nxt;
      im_wr_en    <= accept;
      im_wr_data  <= accept ? in_data : im_wr_data;
      core_req    <= state == REQ;
      word_count  <= clear ? '0 : word_count + {{D{1'b0}}, im_wr_en};
      cycle_count <= (clear || state == REQ) ? '0 : (state == RUN && nxt == RUN) ? cycle_count + 1'b1 : cycle_count;
      ok          <= !clear & (ok | (state == RUN && nxt == DONE));
      timed_out   <= !clear & (timed_out | (state == RUN && nxt == TMO));
      overflow    <= !clear & (overflow | (state == LOAD && nxt == OVF));
    end
  end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized programs checked against expectations derived arithmetically from program length and done timing.
module tb_prog_loader;
  localparam int D = 3, W = 9, CW = 16, MAX = 16;
  logic clk = 0, reset = 1;
  logic in_valid = 0, in_ready, in_last = 0;
  logic [W-1:0] in_data = '0;
  logic im_wr_en;
  logic [D-1:0] im_wr_addr;
  logic [W-1:0] im_wr_data;
  logic core_reset, core_req, core_done = 0, rearm = 0, busy, ok, timed_out, overflow;
  logic [D:0] word_count;
  logic [CW-1:0] cycle_count;
  int n_tests = 0, n_fail = 0;
  logic [W-1:0] prog[$];

  prog_loader #(.D(D), .W(W), .CW(CW), .MAX_CYC(MAX)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .im_wr_en(im_wr_en), .im_wr_addr(im_wr_addr), .im_wr_data(im_wr_data),
    .core_reset(core_reset), .core_req(core_req), .core_done(core_done), .rearm(rearm),
    .busy(busy), .ok(ok), .timed_out(timed_out), .overflow(overflow),
    .word_count(word_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_rand(input int n);
    prog.delete();
    for (int k = 0; k < n; k++) prog.push_back(W'($urandom_range(0, 2**W - 1)));
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, in_ready, 1);
    check({tag, "_creset"}, core_reset, 1);
    check({tag, "_req"}, core_req, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_flags"}, {ok, timed_out, overflow}, 0);
    check({tag, "_wc"}, word_count, 0);
    check({tag, "_cc"}, cycle_count, 0);
  endtask

  task automatic do_rearm;
    rearm = 1;
    tick;
    rearm = 0;
    check_idle("rearm");
  endtask

  // stream prog[] (in_last on final word unless use_last=0), then run with core_done on RUN cycle done_at
  task automatic run_prog(input bit use_last, input int gap, input int done_at, input int rst_at);
    int n, cap, i, guard, end_j;
    bit exp_ok;
    n = prog.size();
    cap = use_last ? n : 2**D;
    i = 0;
    guard = 0;
    while (i < cap && guard < 400) begin
      bit v;
      v = $urandom_range(0, 99) >= gap;
      in_valid = v;
      in_data = prog[i];
      in_last = use_last && i == n - 1;
      core_done = 1'($urandom);
      check("ready_load", in_ready, 1);
      tick;
      guard++;
      check("wr_en", im_wr_en, 32'(v));
      if (v) begin
        check("wr_addr", im_wr_addr, i);
        check("wr_data", im_wr_data, prog[i]);
        i++;
      end
    end
    if (i < cap) check("load_stall", i, cap);
    if (!use_last) begin
      in_valid = 1;
      in_last = 0;
      in_data = prog[n - 1];
      repeat (3) begin
        tick;
        check("ovf_wr_en", im_wr_en, 0);
        check("ovf_ready", in_ready, 0);
      end
      in_valid = 0;
      check("ovf_flags", {ok, timed_out, overflow}, 3'b001);
      check("ovf_wc", word_count, 2**D);
      check("ovf_creset", core_reset, 1);
      check("ovf_busy", busy, 0);
      return;
    end
    in_valid = 0;
    in_last = 0;
    check("rel_creset", core_reset, 1);
    check("rel_busy", busy, 1);
    check("rel_ready", in_ready, 0);
    tick;
    check("req_creset", core_reset, 0);
    check("req_req", core_req, 0);
    check("req_wr_en", im_wr_en, 0);
    check("req_wc", word_count, n);
    tick;
    check("run_req", core_req, 1);
    check("run_cc0", cycle_count, 0);
    check("run_creset", core_reset, 0);
    exp_ok = done_at >= 1 && done_at <= MAX;
    end_j = exp_ok ? done_at : MAX;
    for (int j = 1; j <= end_j; j++) begin
      core_done = j == done_at;
      reset = j == rst_at;
      tick;
      check("run_req_pulse", core_req, 0);
      if (j == rst_at) begin
        reset = 0;
        core_done = 0;
        check("rst_wr_en", im_wr_en, 0);
        check_idle("midrst");
        tick;
        check("midrst_req", core_req, 0);
        return;
      end
      if (j < end_j) begin
        check("run_cc", cycle_count, j);
        check("run_busy", busy, 1);
      end
    end
    core_done = 0;
    check("end_flags", {ok, timed_out, overflow}, exp_ok ? 3'b100 : 3'b010);
    check("end_cc", cycle_count, end_j - 1);
    check("end_busy", busy, 0);
    check("end_creset", core_reset, 1);
    check("end_ready", in_ready, 0);
    repeat (2) begin
      core_done = 1'($urandom);
      tick;
      check("hold_cc", cycle_count, end_j - 1);
      check("hold_flags", {ok, timed_out}, exp_ok ? 2'b10 : 2'b01);
      check("hold_wc", word_count, n);
    end
    core_done = 0;
  endtask

  initial begin
    repeat (2) tick;
    check("rst_wr_en", im_wr_en, 0);
    check_idle("reset");
    reset = 0;
    prog = '{9'h1A5, 9'h0FF, 9'h100};
    run_prog(1, 0, 10, 0);
    do_rearm;
    fill_rand(3);
    run_prog(1, 0, 0, 0);
    do_rearm;
    fill_rand(3);
    run_prog(1, 30, MAX, 0);
    do_rearm;
    fill_rand(2**D + 1);
    run_prog(0, 0, 0, 0);
    do_rearm;
    fill_rand(1);
    run_prog(1, 0, 1, 0);
    do_rearm;
    for (int t = 0; t < 8; t++) begin
      fill_rand($urandom_range(1, 2**D));
      run_prog(1, 40, $urandom_range(0, MAX + 3), 0);
      do_rearm;
    end
    fill_rand(4);
    run_prog(1, 20, 0, 5);
    in_valid = 1;
    in_data = 9'h055;
    reset = 1;
    tick;
    reset = 0;
    in_valid = 0;
    check("rst_accept_wr_en", im_wr_en, 0);
    check("rst_accept_wc", word_count, 0);
    tick;
    check("rst_accept_wr_en2", im_wr_en, 0);
    check_idle("post_rst");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
